// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM states, forwarding selects,
// result-source encodings and a write-type decode helper.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Execute-stage operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // ResultSrcE encoding for a load
  localparam logic [1:0] RES_LOAD = 2'b01;

  // Any nonzero write-type code means the instruction writes a register
  function automatic logic is_write(input logic [2:0] code);
    return code != 3'b000;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding compare for one Execute-stage source operand.
// Ports:
//   rs          source register index in Execute
//   rd_m, rd_w  destination indices in Memory / Writeback
//   regwrite_m, regwrite_w  write-type codes (nonzero = writes a register)
//   fwd         FWD_MEM, FWD_WB or FWD_RF
module forward_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic [2:0]                regwrite_m,
  input  logic [2:0]                regwrite_w,
  output logic [1:0]                fwd
);

  // Memory stage holds the younger result, so it wins; x0 never forwards
  always_comb begin
    fwd = FWD_RF;
    if (is_write(regwrite_m) && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_MEM;
    end else if (is_write(regwrite_w) && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: register enables/flushes for F/D, D/E, E/M and
// M/W, Execute operand forwarding, and a data-memory wait FSM with timeout
// and stall-cycle counter.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   Rs1D, Rs2D                       Decode sources
//   Rs1E, Rs2E, RdE                  Execute sources / destination
//   RdM, RdW                         Memory / Writeback destinations
//   ResultSrcE                       Execute result select (01 = load)
//   RegWriteM, RegWriteW             write-type codes
//   PCSrcE                           taken branch/jump in Execute
//   MemReqM, MemReadyM               data-memory request / completion
//   EnF, EnD, EnE, EnM               register enables (combinational)
//   FlushD, FlushE                   register clears (combinational)
//   ForwardAE, ForwardBE             forwarding selects (combinational)
//   mem_wait                         FSM is in MEM_WAIT (combinational)
//   mem_err                          sticky memory timeout (registered)
//   stall_cycles                     saturating count of EnF=0 cycles
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_WIDTH  = 8,
  parameter int unsigned MEM_TIMEOUT    = 200,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic [1:0]                ResultSrcE,
  input  logic [2:0]                RegWriteM,
  input  logic [2:0]                RegWriteW,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic                      EnF,
  output logic                      EnD,
  output logic                      EnE,
  output logic                      EnM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      mem_wait,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(MEM_TIMEOUT);

  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                     err_d;
  logic                     lw_stall;
  logic [1:0]               fwd_a, fwd_b;

  // One forwarding compare per Execute operand
  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs         (Rs1E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .regwrite_m (RegWriteM),
    .regwrite_w (RegWriteW),
    .fwd        (fwd_a)
  );

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs         (Rs2E),
    .rd_m       (RdM),
    .rd_w       (RdW),
    .regwrite_m (RegWriteM),
    .regwrite_w (RegWriteW),
    .fwd        (fwd_b)
  );

  // Reset forces a clean register-file select
  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;

  // Load in Execute feeding an instruction in Decode
  assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // Enables, flushes and FSM next state
  always_comb begin
    EnF      = 1'b1;
    EnD      = 1'b1;
    EnE      = 1'b1;
    EnM      = 1'b1;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    mem_wait = 1'b0;
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    err_d    = mem_err;

    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            // Freeze everything on the first cycle of a slow access
            EnF     = 1'b0;
            EnD     = 1'b0;
            EnE     = 1'b0;
            EnM     = 1'b0;
            state_d = MEM_WAIT;
            tcnt_d  = TIMEOUT_WIDTH'(1);
          end else if (PCSrcE) begin
            // Wrong-path instructions are squashed; a pending load-use dies with them
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (lw_stall) begin
            // Hold F/D, insert one bubble into D/E
            EnF    = 1'b0;
            EnD    = 1'b0;
            FlushE = 1'b1;
          end
        end
        MEM_WAIT: begin
          mem_wait = 1'b1;
          EnF      = 1'b0;
          EnD      = 1'b0;
          EnE      = 1'b0;
          EnM      = 1'b0;
          if (MemReadyM) begin
            state_d = RUN;
            tcnt_d  = '0;
          end else if (tcnt_q == TIMEOUT_LIMIT) begin
            err_d   = 1'b1;
            state_d = RUN;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TIMEOUT_WIDTH'(1);
          end
        end
      endcase
    end
  end

  // State, timeout counter, sticky error and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      tcnt_q       <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      mem_err <= err_d;
      if (!EnF && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of combinational hazard/forwarding
// vectors plus hand-written multi-cycle sequences for the memory FSM.
module tb_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned TW = 8;
  localparam int unsigned TO = 4;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic [2:0]    RegWriteM, RegWriteW;
  logic          PCSrcE, MemReqM, MemReadyM;
  logic          EnF, EnD, EnE, EnM, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          mem_wait, mem_err;
  logic [CW-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(
    .REG_ADDR_WIDTH(RW),
    .TIMEOUT_WIDTH (TW),
    .MEM_TIMEOUT   (TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_wait(mem_wait), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]    rsrc;
    logic [2:0]    rwm, rww;
    logic          pcsrc;
    logic [3:0]    en;   // {EnF, EnD, EnE, EnM}
    logic [1:0]    fl;   // {FlushD, FlushE}
    logic [1:0]    fa, fb;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(
    input logic [RW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
    input logic [1:0] rsrc, input logic [2:0] rwm, rww, input logic pcsrc,
    input logic [3:0] en, input logic [1:0] fl, fa, fb);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
    v.rdm = rdm; v.rdw = rdw; v.rsrc = rsrc; v.rwm = rwm; v.rww = rww;
    v.pcsrc = pcsrc; v.en = en; v.fl = fl; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = '0; RegWriteM = '0; RegWriteW = '0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Advance past the next rising edge, landing away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] s0;

    //            rs1d rs2d rs1e rs2e rde rdm rdw rsrc rwm rww pc  en       fl     fa     fb
    vecs[0]  = mk(0, 0, 5, 0, 0, 5, 5, 2'b00, 3'b010, 3'b010, 0, 4'b1111, 2'b00, 2'b10, 2'b00);
    vecs[1]  = mk(0, 0, 5, 0, 0, 0, 5, 2'b00, 3'b010, 3'b010, 0, 4'b1111, 2'b00, 2'b01, 2'b00);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 3'b010, 0, 4'b1111, 2'b00, 2'b00, 2'b00);
    vecs[3]  = mk(0, 0, 5, 0, 0, 5, 5, 2'b00, 3'b000, 3'b010, 0, 4'b1111, 2'b00, 2'b01, 2'b00);
    vecs[4]  = mk(0, 0, 3, 9, 0, 9, 3, 2'b00, 3'b001, 3'b100, 0, 4'b1111, 2'b00, 2'b01, 2'b10);
    vecs[5]  = mk(0, 7, 0, 0, 7, 0, 0, 2'b01, 3'b000, 3'b000, 0, 4'b0011, 2'b01, 2'b00, 2'b00);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 3'b000, 0, 4'b1111, 2'b00, 2'b00, 2'b00);
    vecs[7]  = mk(7, 0, 0, 0, 7, 0, 0, 2'b10, 3'b000, 3'b000, 0, 4'b1111, 2'b00, 2'b00, 2'b00);
    vecs[8]  = mk(0, 7, 0, 0, 7, 0, 0, 2'b01, 3'b000, 3'b000, 1, 4'b1111, 2'b11, 2'b00, 2'b00);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 1, 4'b1111, 2'b11, 2'b00, 2'b00);
    vecs[10] = mk(12, 0, 0, 12, 12, 0, 12, 2'b01, 3'b000, 3'b111, 0, 4'b0011, 2'b01, 2'b00, 2'b01);

    // Reset: forced outputs even with a forwarding match present
    clear_in();
    rst = 1'b1;
    Rs1E = 5; RdM = 5; RegWriteM = 3'b010;
    step(); step();
    check("rst_EnF", 32'(EnF), 32'd1);
    check("rst_flush", 32'({FlushD, FlushE}), 32'b11);
    check("rst_fwdA", 32'(ForwardAE), 32'b00);
    check("rst_mem_wait", 32'(mem_wait), 32'd0);
    clear_in();
    rst = 1'b0;
    step();
    check("post_rst_stall_cycles", stall_cycles, 32'd0);
    check("post_rst_mem_err", 32'(mem_err), 32'd0);

    // Table-driven combinational vectors
    for (int i = 0; i < 11; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
      Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      ResultSrcE = vecs[i].rsrc; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      PCSrcE = vecs[i].pcsrc;
      #1;
      check($sformatf("vec%0d_en", i), 32'({EnF, EnD, EnE, EnM}), 32'(vecs[i].en));
      check($sformatf("vec%0d_flush", i), 32'({FlushD, FlushE}), 32'(vecs[i].fl));
      check($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(vecs[i].fa));
      check($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(vecs[i].fb));
      step();
    end

    // Load-use: one bubble cycle, then the bubble sits in Execute
    clear_in();
    step();
    s0 = stall_cycles;
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    check("lu_stall_en", 32'({EnF, EnD, EnE, EnM}), 32'b0011);
    check("lu_stall_flushE", 32'(FlushE), 32'd1);
    step();
    ResultSrcE = 2'b00; RdE = 0;
    #1;
    check("lu_after_en", 32'({EnF, EnD, EnE, EnM}), 32'b1111);
    check("lu_after_flush", 32'({FlushD, FlushE}), 32'b00);
    check("lu_stall_count", stall_cycles, s0 + 32'd1);

    // Branch over load-use: no stall cycle counted
    s0 = stall_cycles;
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1'b1;
    #1;
    check("br_en", 32'({EnF, EnD}), 32'b11);
    check("br_flush", 32'({FlushD, FlushE}), 32'b11);
    step();
    clear_in();
    #1;
    check("br_stall_count", stall_cycles, s0);

    // Memory wait: ready low for 3 cycles then high
    step();
    s0 = stall_cycles;
    MemReqM = 1'b1; MemReadyM = 1'b0;
    #1;
    check("mw_c1_en", 32'({EnF, EnD, EnE, EnM}), 32'b0000);
    check("mw_c1_mem_wait", 32'(mem_wait), 32'd0);
    step();
    check("mw_c2_mem_wait", 32'(mem_wait), 32'd1);
    check("mw_c2_en", 32'({EnF, EnD, EnE, EnM}), 32'b0000);
    step();
    check("mw_c3_mem_wait", 32'(mem_wait), 32'd1);
    step();
    MemReadyM = 1'b1;
    #1;
    check("mw_c4_mem_wait", 32'(mem_wait), 32'd1);
    check("mw_c4_en", 32'({EnF, EnD, EnE, EnM}), 32'b0000);
    step();
    MemReqM = 1'b0; MemReadyM = 1'b0;
    #1;
    check("mw_c5_mem_wait", 32'(mem_wait), 32'd0);
    check("mw_c5_en", 32'({EnF, EnD, EnE, EnM}), 32'b1111);
    check("mw_stall_count", stall_cycles, s0 + 32'd4);
    check("mw_no_err", 32'(mem_err), 32'd0);

    // Timeout: 1 RUN stall cycle + 4 MEM_WAIT cycles, then error and RUN
    step();
    s0 = stall_cycles;
    MemReqM = 1'b1; MemReadyM = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("to_wait%0d_mem_wait", k), 32'(mem_wait), 32'd1);
      check($sformatf("to_wait%0d_err", k), 32'(mem_err), 32'd0);
      step();
    end
    MemReqM = 1'b0;
    #1;
    check("to_err_set", 32'(mem_err), 32'd1);
    check("to_back_run", 32'(mem_wait), 32'd0);
    check("to_run_en", 32'(EnF), 32'd1);
    check("to_stall_count", stall_cycles, s0 + 32'd5);
    step(); step(); step();
    check("to_err_sticky", 32'(mem_err), 32'd1);

    // Reset in the middle of MEM_WAIT
    MemReqM = 1'b1; MemReadyM = 1'b0;
    step();
    check("rw_in_wait", 32'(mem_wait), 32'd1);
    rst = 1'b1;
    #1;
    check("rw_rst_flush", 32'({FlushD, FlushE}), 32'b11);
    check("rw_rst_en", 32'({EnF, EnD, EnE, EnM}), 32'b1111);
    check("rw_rst_mem_wait", 32'(mem_wait), 32'd0);
    step();
    rst = 1'b0;
    MemReqM = 1'b0;
    #1;
    check("rw_after_mem_wait", 32'(mem_wait), 32'd0);
    check("rw_after_en", 32'(EnF), 32'd1);
    check("rw_after_stall_cycles", stall_cycles, 32'd0);
    check("rw_after_mem_err", 32'(mem_err), 32'd0);
    step();
    check("rw_stays_run", 32'(mem_wait), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
